montre_tick_master: RTL and testbench
=====================================

# montre_tick_master

Avalon-MM initiator that owns the 16-bit interval-timer slave in the watch SoC and turns its timeout interrupt into a BCD time-of-day. After reset it programs the timer period, starts it in continuous mode with interrupt enabled, and reads back status to confirm it is running. On each interrupt it clears the timer status and advances hh:mm:ss. The Nios core is not involved, so the watch keeps time in hardware alone.

## Interface
- PERIOD_M1, 32'd49_999_999, value written to period_h:period_l; tick period is PERIOD_M1+1 clk cycles
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high; one clock domain
- avm_address  out  3  timer register index: 0 status, 1 control, 2 period_l, 3 period_h
- avm_chipselect  out  1  high during any access
- avm_write_n  out  1  low during write cycles
- avm_writedata  out  16  write data
- avm_readdata  in  16  timer read data, registered by the slave; valid the cycle after the address is presented
- timer_irq  in  1  timer timeout interrupt, level
- set_time  in  1  one-cycle pulse; loads set_hh/set_mm/set_ss
- set_hh, set_mm, set_ss  in  8 each  BCD load values
- hours, minutes, seconds  out  8 each  BCD time of day
- tick  out  1  one-cycle pulse per accepted second
- running  out  1  high once the status readback has confirmed the timer is running
- error  out  1  sticky; set on a failed readback, cleared by reset

## Operation
- FSM states: INIT_PL, INIT_PH, INIT_CTL, CHK_ADDR, CHK_DATA, IDLE, ACK, ACK_WAIT.
- INIT_PL: write addr 2, data PERIOD_M1[15:0].
- INIT_PH: write addr 3, data PERIOD_M1[31:16].
- INIT_CTL: write addr 1, data 16'h0007 (interrupt enable, continuous, start).
- CHK_ADDR: read addr 0 (chipselect=1, write_n=1).
- CHK_DATA: sample avm_readdata[1] (the running bit).
  - If set: running<=1, go to IDLE.
  - If clear: error<=1, go back to INIT_PL. The init sequence is retried indefinitely.
- IDLE: bus inactive (chipselect=0, write_n=1, address=0, writedata=0). When timer_irq=1, go to ACK.
- ACK: write addr 0, data 0 (clears the timeout), and advance the time by one second. tick=1 in this cycle.
- ACK_WAIT: one idle cycle, then go to IDLE.
  - This is required because timer_irq falls one cycle after the clearing write. Without it the same timeout would be counted twice.
- Time arithmetic is BCD digit-wise:
  - ss 59 -> 00 carries into mm.
  - mm 59 -> 00 carries into hh.
  - hh 23 -> 00 wraps; there is no date carry.
- set_time:
  - Loads all three fields at once, only when every digit is valid BCD and hh<=23, mm<=59, ss<=59.
  - Otherwise it is ignored entirely; no field changes.
  - It is accepted in any state.
- Simultaneous set_time and ACK increment: the load wins and the increment is dropped. tick still pulses.

## Timing
- Every bus access lasts exactly one cycle; the slave has no waitrequest.
- Reset values:
  - state=INIT_PL, chipselect=0, write_n=1, address=0, writedata=0.
  - hours=minutes=seconds=8'h00, tick=0, running=0, error=0.
- First write appears in the first cycle after reset deasserts. Sequence: writes on cycles 1, 2, 3; read on cycle 4; sample on cycle 5; IDLE from cycle 6.
- Interrupt latency:
  - timer_irq is sampled high in IDLE at cycle N.
  - The clearing write and the time update happen at cycle N+1, and seconds shows the new value from N+2.
  - IDLE is re-entered at N+3.
- Re-entering INIT_PL via reset mid-operation aborts any bus cycle immediately; no partial write is held over.
- timer_irq is ignored in every state except IDLE. An interrupt asserted during init is serviced once IDLE is reached.

## Structure
- A shared package holds:
  - timer register indices (status, control, period_l, period_h);
  - the control word 16'h0007 and the running-bit index 1;
  - the FSM state enum.
- One sub-module: montre_bcd_clock. It holds the hh:mm:ss counters with increment, validated load, and carry/wrap logic. The FSM instantiates it and drives inc/load.

## Test plan
- PERIOD_M1=32'h0012_3456, reset released -> bus shows wr(2,16'h3456), wr(3,16'h0012), wr(1,16'h0007), rd(0) on cycles 1-4; readdata=16'h0002 -> running=1 on cycle 6, error=0.
- Readback 16'h0000 -> error=1, running=0, init sequence reissued starting from cycle 6.
- Slave model with PERIOD_M1=9, irq held until the status write -> exactly one tick per 10 cycles, wr(0,0) once per irq, seconds 00->01->02.
- set_time 23/59/58, then two interrupts -> 23:59:59 then 00:00:00, each with one tick.
- set_time with set_mm=8'h60 -> ignored, time unchanged; set_time in the same cycle as ACK with 12:00:00 -> reads 12:00:00 afterwards, not 12:00:01.
- Reset asserted during ACK_WAIT -> next cycle shows reset values and the init writes restart; the time reads 00:00:00.

Source files
------------

// File: rtl/montre_tick_master_pkg.sv
// montre_tick_master_pkg
// Shared definitions for the watch tick master and its BCD clock:
//   - interval-timer register indices on the Avalon-MM slave
//   - control word that starts the timer continuous with interrupt enabled
//   - index of the "running" bit in the timer status register
//   - FSM state encoding for the tick master
//   - BCD helpers for range validation and digit-wise increment
package montre_tick_master_pkg;

  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_CONTROL  = 3'd1;
  localparam logic [2:0] REG_PERIOD_L = 3'd2;
  localparam logic [2:0] REG_PERIOD_H = 3'd3;

  // ITO | CONT | START
  localparam logic [15:0] CTRL_RUN_CONT_IRQ = 16'h0007;

  localparam int STATUS_RUN_BIT = 1;

  typedef enum logic [2:0] {
    INIT_PL,
    INIT_PH,
    INIT_CTL,
    CHK_ADDR,
    CHK_DATA,
    IDLE,
    ACK,
    ACK_WAIT
  } state_t;

  // Both digits must be decimal and the packed value must not exceed max_v.
  // For valid BCD the hex ordering equals the decimal ordering.
  function automatic logic bcd_in_range(input logic [7:0] v, input logic [7:0] max_v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max_v);
  endfunction

  // Two-digit BCD increment that wraps to 00 after reaching last.
  function automatic logic [7:0] bcd_next(input logic [7:0] v, input logic [7:0] last);
    logic [7:0] r;
    if (v == last) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/montre_bcd_clock.sv
// montre_bcd_clock
// hh:mm:ss time-of-day counters in packed BCD.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   inc               advance the time by one second
//   load              request to load set_hh/set_mm/set_ss (validated)
//   set_hh/mm/ss      BCD load values
//   hours/minutes/seconds  current BCD time of day
// A valid load takes priority over an increment in the same cycle; an
// invalid load is dropped entirely and does not block the increment.
module montre_bcd_clock
  import montre_tick_master_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic [7:0] set_ss,
  output logic [7:0] hours,
  output logic [7:0] minutes,
  output logic [7:0] seconds
);

  logic load_ok;

  assign load_ok = load
                   && bcd_in_range(set_hh, 8'h23)
                   && bcd_in_range(set_mm, 8'h59)
                   && bcd_in_range(set_ss, 8'h59);

  // Time registers: a validated load replaces all three fields at once,
  // otherwise an increment ripples carries from seconds up to hours.
  // Hours wrap 23 -> 00 with no further carry.
  always_ff @(posedge clk) begin
    if (reset) begin
      hours   <= 8'h00;
      minutes <= 8'h00;
      seconds <= 8'h00;
    end else if (load_ok) begin
      hours   <= set_hh;
      minutes <= set_mm;
      seconds <= set_ss;
    end else if (inc) begin
      seconds <= bcd_next(seconds, 8'h59);
      if (seconds == 8'h59) begin
        minutes <= bcd_next(minutes, 8'h59);
        if (minutes == 8'h59) begin
          hours <= bcd_next(hours, 8'h23);
        end
      end
    end
  end

endmodule

// File: rtl/montre_tick_master.sv
// montre_tick_master
// Avalon-MM initiator that programs the interval timer, confirms it runs,
// and converts each timeout interrupt into a one-second BCD time advance.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   avm_address         timer register index
//   avm_chipselect      high during any access
//   avm_write_n         low during write cycles
//   avm_writedata       write data
//   avm_readdata        registered slave read data (valid one cycle after address)
//   timer_irq           timer timeout interrupt, level
//   set_time            one-cycle pulse loading set_hh/set_mm/set_ss
//   hours/minutes/seconds  BCD time of day
//   tick                one-cycle pulse per serviced timeout
//   running             timer confirmed running by status readback
//   error               sticky flag for a failed readback
module montre_tick_master
  import montre_tick_master_pkg::*;
#(
  parameter logic [31:0] PERIOD_M1 = 32'd49_999_999
) (
  input  logic        clk,
  input  logic        reset,
  output logic [2:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [15:0] avm_writedata,
  input  logic [15:0] avm_readdata,
  input  logic        timer_irq,
  input  logic        set_time,
  input  logic [7:0]  set_hh,
  input  logic [7:0]  set_mm,
  input  logic [7:0]  set_ss,
  output logic [7:0]  hours,
  output logic [7:0]  minutes,
  output logic [7:0]  seconds,
  output logic        tick,
  output logic        running,
  output logic        error
);

  state_t state;
  state_t next_state;
  logic   inc;
  logic   unused_readdata;

  // Only the running bit of the status word matters here.
  assign unused_readdata = ^{avm_readdata[15:2], avm_readdata[0]};

  // State register plus the readback result flags. running and error are
  // only ever set here; reset is the only way to clear them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= INIT_PL;
      running <= 1'b0;
      error   <= 1'b0;
    end else begin
      state <= next_state;
      if (state == CHK_DATA) begin
        if (avm_readdata[STATUS_RUN_BIT]) begin
          running <= 1'b1;
        end else begin
          error <= 1'b1;
        end
      end
    end
  end

  // Next-state and bus decode. Each state owns exactly one bus cycle, so
  // the bus outputs follow the state directly. While reset is asserted the
  // bus is forced idle, so an access in progress is dropped at once.
  always_comb begin
    next_state     = state;
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_address    = 3'd0;
    avm_writedata  = 16'h0000;
    tick           = 1'b0;
    inc            = 1'b0;

    case (state)
      INIT_PL: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = REG_PERIOD_L;
        avm_writedata  = PERIOD_M1[15:0];
        next_state     = INIT_PH;
      end
      INIT_PH: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = REG_PERIOD_H;
        avm_writedata  = PERIOD_M1[31:16];
        next_state     = INIT_CTL;
      end
      INIT_CTL: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = REG_CONTROL;
        avm_writedata  = CTRL_RUN_CONT_IRQ;
        next_state     = CHK_ADDR;
      end
      CHK_ADDR: begin
        avm_chipselect = 1'b1;
        avm_address    = REG_STATUS;
        next_state     = CHK_DATA;
      end
      CHK_DATA: begin
        next_state = avm_readdata[STATUS_RUN_BIT] ? IDLE : INIT_PL;
      end
      IDLE: begin
        if (timer_irq) begin
          next_state = ACK;
        end
      end
      ACK: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = REG_STATUS;
        avm_writedata  = 16'h0000;
        tick           = 1'b1;
        inc            = 1'b1;
        next_state     = ACK_WAIT;
      end
      ACK_WAIT: begin
        // timer_irq is still high this cycle; skipping it avoids counting
        // the same timeout twice.
        next_state = IDLE;
      end
      default: begin
        next_state = INIT_PL;
      end
    endcase

    if (reset) begin
      avm_chipselect = 1'b0;
      avm_write_n    = 1'b1;
      avm_address    = 3'd0;
      avm_writedata  = 16'h0000;
      tick           = 1'b0;
      inc            = 1'b0;
    end
  end

  montre_bcd_clock u_clock (
    .clk     (clk),
    .reset   (reset),
    .inc     (inc),
    .load    (set_time),
    .set_hh  (set_hh),
    .set_mm  (set_mm),
    .set_ss  (set_ss),
    .hours   (hours),
    .minutes (minutes),
    .seconds (seconds)
  );

endmodule

// File: tb/tb_montre_tick_master.sv
// tb_montre_tick_master
// Scoreboard bench: stimulus pushes expected bus accesses and expected
// time-of-day transitions; a monitor pops and compares whenever the DUT
// drives a bus access or a tick.
module tb_montre_tick_master;

  localparam logic [31:0] DUT_PERIOD_M1   = 32'h0012_3456;
  localparam int          SLAVE_PERIOD_M1 = 9;

  logic        clk;
  logic        reset;
  logic [2:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [15:0] avm_writedata;
  logic [15:0] avm_readdata = 16'h0000;
  logic        timer_irq = 1'b0;
  logic        set_time;
  logic [7:0]  set_hh;
  logic [7:0]  set_mm;
  logic [7:0]  set_ss;
  logic [7:0]  hours;
  logic [7:0]  minutes;
  logic [7:0]  seconds;
  logic        tick;
  logic        running;
  logic        error;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] data;
    logic        tk;
    int          at_cyc;
  } bus_exp_t;

  typedef struct {
    logic [23:0] t_pre;
    logic [23:0] t_post;
  } time_exp_t;

  bus_exp_t  bus_q[$];
  time_exp_t time_q[$];
  int        tick_stamps[$];

  // Slave-model controls written only by the stimulus process
  logic [15:0] status_word = 16'h0002;
  int          irq_req_cnt = 0;
  int          periodic_total = 0;
  // Slave-model state written only by the slave process
  int          irq_req_seen = 0;
  int          periodic_done = 0;
  int          period_cnt = SLAVE_PERIOD_M1;

  montre_tick_master #(.PERIOD_M1(DUT_PERIOD_M1)) dut (
    .clk            (clk),
    .reset          (reset),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .timer_irq      (timer_irq),
    .set_time       (set_time),
    .set_hh         (set_hh),
    .set_mm         (set_mm),
    .set_ss         (set_ss),
    .hours          (hours),
    .minutes        (minutes),
    .seconds        (seconds),
    .tick           (tick),
    .running        (running),
    .error          (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter used to time-stamp bus accesses
  always @(posedge clk) cyc <= cyc + 1;

  // Interval-timer slave model: registered readdata, irq held until a
  // status write, periodic timeouts every SLAVE_PERIOD_M1+1 cycles while
  // requested, and one-shot timeouts on demand.
  always @(posedge clk) begin
    if (avm_chipselect === 1'b1 && avm_write_n === 1'b1)
      avm_readdata <= (avm_address == 3'd0) ? status_word : 16'h0000;
    if (avm_chipselect === 1'b1 && avm_write_n === 1'b0 && avm_address == 3'd0)
      timer_irq <= 1'b0;
    if (periodic_done < periodic_total) begin
      if (period_cnt == 0) begin
        timer_irq     <= 1'b1;
        periodic_done <= periodic_done + 1;
        period_cnt    <= SLAVE_PERIOD_M1;
      end else begin
        period_cnt <= period_cnt - 1;
      end
    end
    if (irq_req_cnt != irq_req_seen) begin
      timer_irq    <= 1'b1;
      irq_req_seen <= irq_req_cnt;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic pushBus(input logic wr, input logic [2:0] addr, input logic [15:0] data,
                         input logic tk, input int at_cyc);
    bus_exp_t e;
    e.wr = wr; e.addr = addr; e.data = data; e.tk = tk; e.at_cyc = at_cyc;
    bus_q.push_back(e);
  endtask

  task automatic pushTime(input logic [23:0] t_pre, input logic [23:0] t_post);
    time_exp_t e;
    e.t_pre = t_pre; e.t_post = t_post;
    time_q.push_back(e);
  endtask

  task automatic pushInit(input int base);
    pushBus(1'b1, 3'd2, 16'h3456, 1'b0, base);
    pushBus(1'b1, 3'd3, 16'h0012, 1'b0, base + 1);
    pushBus(1'b1, 3'd1, 16'h0007, 1'b0, base + 2);
    pushBus(1'b0, 3'd0, 16'h0000, 1'b0, base + 3);
  endtask

  task automatic waitCycle(input int target);
    @(negedge clk);
    while (cyc < target) @(negedge clk);
  endtask

  // One-cycle set_time pulse with the given fields
  task automatic applyStimulus(input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss);
    @(posedge clk); #1;
    set_time = 1'b1; set_hh = hh; set_mm = mm; set_ss = ss;
    @(posedge clk); #1;
    set_time = 1'b0;
  endtask

  // Single timeout: irq rises after cycle x, ACK write expected at x+2
  task automatic serviceIrq(input logic [23:0] t_pre, input logic [23:0] t_post);
    int x;
    @(posedge clk); #1;
    x = cyc;
    pushTime(t_pre, t_post);
    pushBus(1'b1, 3'd0, 16'h0000, 1'b1, x + 2);
    irq_req_cnt++;
    repeat (6) @(posedge clk);
  endtask

  // Monitor: compares every bus access and every tick against the queues
  initial begin
    bus_exp_t  be;
    time_exp_t te;
    logic        time_pending;
    logic [23:0] time_post_exp;
    time_pending = 1'b0;
    time_post_exp = 24'h0;
    forever begin
      @(negedge clk);
      if (time_pending) begin
        checkOutput("time_after_tick", {8'h00, hours, minutes, seconds}, {8'h00, time_post_exp});
        time_pending = 1'b0;
      end
      if (avm_chipselect === 1'b1) begin
        if (bus_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL bus_unexpected: got wr=%0b addr=%0d data=%h, expected no access (cycle %0d)",
                   !avm_write_n, avm_address, avm_writedata, cyc);
        end else begin
          be = bus_q.pop_front();
          checkOutput("bus_kind", {27'd0, !avm_write_n, avm_address, tick}, {27'd0, be.wr, be.addr, be.tk});
          if (be.wr) checkOutput("bus_wdata", {16'd0, avm_writedata}, {16'd0, be.data});
          if (be.at_cyc >= 0) checkOutput("bus_cycle", cyc, be.at_cyc);
        end
      end
      if (tick === 1'b1) begin
        tick_stamps.push_back(cyc);
        if (time_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL tick_unexpected: got tick=1 at time %h%h%h, expected none (cycle %0d)",
                   hours, minutes, seconds, cyc);
        end else begin
          te = time_q.pop_front();
          checkOutput("time_at_tick", {8'h00, hours, minutes, seconds}, {8'h00, te.t_pre});
          time_post_exp = te.t_post;
          time_pending = 1'b1;
        end
      end
    end
  end

  initial begin
    int base;
    int x;
    int n0;
    reset = 1'b1;
    set_time = 1'b0; set_hh = 8'h00; set_mm = 8'h00; set_ss = 8'h00;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_chipselect", {31'd0, avm_chipselect}, 32'd0);
    checkOutput("rst_write_n",    {31'd0, avm_write_n}, 32'd1);
    checkOutput("rst_address",    {29'd0, avm_address}, 32'd0);
    checkOutput("rst_writedata",  {16'd0, avm_writedata}, 32'd0);
    checkOutput("rst_time",       {8'h00, hours, minutes, seconds}, 32'h0);
    checkOutput("rst_flags",      {29'd0, tick, running, error}, 32'd0);

    // Init sequence with a successful readback
    $display("[TB] init sequence, readback 0x0002");
    status_word = 16'h0002;
    base = cyc + 1;
    pushInit(base);
    @(posedge clk); #1; reset = 1'b0;
    waitCycle(base + 4);
    checkOutput("running_cycle5", {31'd0, running}, 32'd0);
    waitCycle(base + 5);
    checkOutput("running_cycle6", {31'd0, running}, 32'd1);
    checkOutput("error_cycle6",   {31'd0, error}, 32'd0);

    // Failed readback, then a retry that succeeds
    $display("[TB] failed readback and retry");
    status_word = 16'h0000;
    @(posedge clk); #1; reset = 1'b1;
    base = cyc + 1;
    pushInit(base);
    pushInit(base + 5);
    @(posedge clk); #1; reset = 1'b0;
    waitCycle(base + 5);
    checkOutput("error_after_fail",   {31'd0, error}, 32'd1);
    checkOutput("running_after_fail", {31'd0, running}, 32'd0);
    status_word = 16'h0002;
    waitCycle(base + 10);
    checkOutput("running_after_retry", {31'd0, running}, 32'd1);
    checkOutput("error_sticky",        {31'd0, error}, 32'd1);

    // Periodic timeouts every 10 cycles, irq held until the status write
    $display("[TB] periodic timeouts");
    @(posedge clk); #1;
    n0 = tick_stamps.size();
    for (int i = 0; i < 3; i++) pushBus(1'b1, 3'd0, 16'h0000, 1'b1, -1);
    pushTime(24'h000000, 24'h000001);
    pushTime(24'h000001, 24'h000002);
    pushTime(24'h000002, 24'h000003);
    periodic_total = periodic_total + 3;
    repeat (40) @(posedge clk);
    #1;
    checkOutput("periodic_tick_count", tick_stamps.size() - n0, 32'd3);
    if (tick_stamps.size() - n0 == 3) begin
      checkOutput("tick_spacing_1", tick_stamps[n0 + 1] - tick_stamps[n0], 32'd10);
      checkOutput("tick_spacing_2", tick_stamps[n0 + 2] - tick_stamps[n0 + 1], 32'd10);
    end

    // Rollover 23:59:58 -> 23:59:59 -> 00:00:00
    $display("[TB] midnight rollover");
    applyStimulus(8'h23, 8'h59, 8'h58);
    @(negedge clk);
    checkOutput("set_235958", {8'h00, hours, minutes, seconds}, 32'h00235958);
    serviceIrq(24'h235958, 24'h235959);
    serviceIrq(24'h235959, 24'h000000);

    // Invalid loads are ignored
    $display("[TB] invalid set_time");
    applyStimulus(8'h12, 8'h60, 8'h00);
    @(negedge clk);
    checkOutput("set_mm_60_ignored", {8'h00, hours, minutes, seconds}, 32'h00000000);
    applyStimulus(8'h10, 8'h20, 8'h5A);
    @(negedge clk);
    checkOutput("set_ss_5a_ignored", {8'h00, hours, minutes, seconds}, 32'h00000000);
    applyStimulus(8'h24, 8'h00, 8'h00);
    @(negedge clk);
    checkOutput("set_hh_24_ignored", {8'h00, hours, minutes, seconds}, 32'h00000000);

    // set_time in the ACK cycle: load wins, tick still pulses
    $display("[TB] set_time during ACK");
    @(posedge clk); #1;
    x = cyc;
    pushTime(24'h000000, 24'h120000);
    pushBus(1'b1, 3'd0, 16'h0000, 1'b1, x + 2);
    irq_req_cnt++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    set_time = 1'b1; set_hh = 8'h12; set_mm = 8'h00; set_ss = 8'h00;
    @(posedge clk); #1;
    set_time = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("load_beats_inc", {8'h00, hours, minutes, seconds}, 32'h00120000);

    // Reset asserted during ACK_WAIT
    $display("[TB] reset during ACK_WAIT");
    @(posedge clk); #1;
    x = cyc;
    pushTime(24'h120000, 24'h120001);
    pushBus(1'b1, 3'd0, 16'h0000, 1'b1, x + 2);
    irq_req_cnt++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    base = cyc + 1;
    pushInit(base);
    @(negedge clk);
    checkOutput("rst_abort_chipselect", {31'd0, avm_chipselect}, 32'd0);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_time",  {8'h00, hours, minutes, seconds}, 32'h0);
    checkOutput("post_rst_flags", {29'd0, tick, running, error}, 32'd0);
    waitCycle(base + 5);
    checkOutput("post_rst_running", {31'd0, running}, 32'd1);

    repeat (5) @(negedge clk);
    checkOutput("bus_q_drained",  bus_q.size(), 32'd0);
    checkOutput("time_q_drained", time_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
